// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the AXI-to-APB bridge.
// The APB master engine and the AXI-side handler both import this package.
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_SETUP     = 2'd2,
        ST_ACCESS    = 2'd3
    } apb_state_t;

    localparam logic [31:0] SLV0_BASE_ADDR = 32'h0001_F000;
    localparam logic [31:0] SLV1_BASE_ADDR = 32'h0002_F000;
    localparam logic [31:0] WINDOW_MASK    = 32'hFFFF_F000;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // Word index inside a 4 KB page; natural 10-bit overflow wraps to the page start.
    function automatic logic [9:0] next_word(input logic [9:0] word);
        return word + 10'd1;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational decode of an address into one of two 4 KB slave windows.
module apb_addr_decode
    import apb_bridge_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] SLV0_BASE  = ADDR_WIDTH'(SLV0_BASE_ADDR),
    parameter logic [ADDR_WIDTH-1:0] SLV1_BASE  = ADDR_WIDTH'(SLV1_BASE_ADDR)
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [1:0]            sel,
    output logic                  hit
);

    localparam logic [ADDR_WIDTH-1:0] WIN_MASK = ~ADDR_WIDTH'(~WINDOW_MASK);

    logic match0;
    logic match1;

    assign match0 = (((addr ^ SLV0_BASE) & WIN_MASK) == '0);
    assign match1 = (((addr ^ SLV1_BASE) & WIN_MASK) == '0);

    // Slave 0 takes priority should the two windows ever be configured to overlap.
    always_comb begin
        sel = 2'b00;
        if (match0) begin
            sel = 2'b01;
        end else if (match1) begin
            sel = 2'b10;
        end
    end

    assign hit = |sel;

endmodule

// File: rtl/apb_master_ctrl.sv
// APB3 master engine of the AXI-to-APB bridge: runs read/write bursts beat by beat
// as SETUP/ACCESS transfers and reports read data, completion and error status.
module apb_master_ctrl
    import apb_bridge_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    TIMEOUT_CYCLES = 16,
    parameter logic [ADDR_WIDTH-1:0] SLV0_BASE      = ADDR_WIDTH'(SLV0_BASE_ADDR),
    parameter logic [ADDR_WIDTH-1:0] SLV1_BASE      = ADDR_WIDTH'(SLV1_BASE_ADDR)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_trans_i,
    input  logic                  rd_trans_i,
    input  logic [ADDR_WIDTH-1:0] trans_addr_i,
    input  logic [3:0]            burst_len_i,
    output logic [DATA_WIDTH-1:0] read_data_o,
    output logic                  trans_done_o,
    output logic                  trans_error_o,
    input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rden_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [1:0]            psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i,
    output logic                  busy_o
);

    localparam int              CW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0]   WAIT_LAST  = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    apb_state_t            state;
    apb_state_t            state_nxt;

    logic                  rd_prev;
    logic                  wr_prev;
    logic                  rd_rise;
    logic                  wr_rise;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            beats_left;
    logic                  is_read;
    logic                  err_acc;
    logic [CW-1:0]         wait_cnt;

    logic [1:0]            dec_sel;
    logic                  dec_hit;

    logic                  beat_end;
    logic                  beat_err;
    logic                  timeout;
    logic                  last_beat;
    logic                  apb_active;
    logic                  start;

    apb_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .SLV0_BASE  (SLV0_BASE),
        .SLV1_BASE  (SLV1_BASE)
    ) u_decode (
        .addr (addr_q),
        .sel  (dec_sel),
        .hit  (dec_hit)
    );

    assign rd_rise   = rd_trans_i & ~rd_prev;
    assign wr_rise   = wr_trans_i & ~wr_prev;
    assign start     = (state == ST_IDLE) && (rd_rise || wr_rise);
    assign last_beat = (beats_left == 4'd0);

    // Edge detectors track the request levels continuously, so a level that rises
    // while a burst is running never starts a transaction later on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_prev <= 1'b0;
            wr_prev <= 1'b0;
        end else begin
            rd_prev <= rd_trans_i;
            wr_prev <= wr_trans_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An undecoded beat ends in SETUP without ever raising psel or penable.
    always_comb begin
        state_nxt   = state;
        beat_end    = 1'b0;
        beat_err    = 1'b0;
        timeout     = 1'b0;
        fifo_rden_o = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rd_rise) begin
                    state_nxt = ST_SETUP;
                end else if (wr_rise) begin
                    state_nxt = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (!fifo_empty_i) begin
                    fifo_rden_o = 1'b1;
                    state_nxt   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (dec_hit) begin
                    state_nxt = ST_ACCESS;
                end else begin
                    beat_end = 1'b1;
                    beat_err = 1'b1;
                end
            end
            ST_ACCESS: begin
                timeout = TIMEOUT_EN && !pready_i && (wait_cnt == WAIT_LAST);
                if (pready_i || timeout) begin
                    beat_end = 1'b1;
                    beat_err = (pready_i & pslverr_i) | timeout;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (beat_end) begin
            if (last_beat) begin
                state_nxt = ST_IDLE;
            end else if (is_read) begin
                state_nxt = ST_SETUP;
            end else begin
                state_nxt = ST_WAIT_DATA;
            end
        end
    end

    assign apb_active = (state == ST_SETUP) || (state == ST_ACCESS);
    assign psel_o     = apb_active ? dec_sel : 2'b00;
    assign penable_o  = (state == ST_ACCESS);
    assign pwrite_o   = apb_active & ~is_read;
    assign paddr_o    = addr_q;
    assign busy_o     = (state != ST_IDLE);

    // Reads report every beat; writes fold beat errors together and report once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q        <= '0;
            beats_left    <= 4'd0;
            is_read       <= 1'b0;
            err_acc       <= 1'b0;
            wait_cnt      <= '0;
            pwdata_o      <= '0;
            read_data_o   <= '0;
            trans_done_o  <= 1'b0;
            trans_error_o <= 1'b0;
        end else begin
            trans_done_o  <= 1'b0;
            trans_error_o <= 1'b0;

            if (start) begin
                addr_q     <= trans_addr_i;
                beats_left <= burst_len_i;
                is_read    <= rd_rise;
                err_acc    <= 1'b0;
            end

            if (fifo_rden_o) begin
                pwdata_o <= fifo_rdata_i;
            end

            if (state == ST_SETUP) begin
                wait_cnt <= '0;
            end else if (state == ST_ACCESS && wait_cnt != '1) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (beat_end) begin
                if (is_read) begin
                    read_data_o   <= (state == ST_ACCESS && pready_i) ? prdata_i : '0;
                    trans_done_o  <= 1'b1;
                    trans_error_o <= beat_err;
                end else begin
                    err_acc <= err_acc | beat_err;
                    if (last_beat) begin
                        trans_done_o  <= 1'b1;
                        trans_error_o <= err_acc | beat_err;
                    end
                end
                if (!last_beat) begin
                    beats_left <= beats_left - 4'd1;
                    addr_q     <= {addr_q[ADDR_WIDTH-1:12], next_word(addr_q[11:2]), addr_q[1:0]};
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed testbench for apb_master_ctrl with a bench-side APB slave and write FIFO.
module tb_apb_master_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr_trans_i = 1'b0;
    logic        rd_trans_i = 1'b0;
    logic [31:0] trans_addr_i = '0;
    logic [3:0]  burst_len_i = '0;
    logic [31:0] read_data_o;
    logic        trans_done_o;
    logic        trans_error_o;
    logic [31:0] fifo_rdata_i;
    logic        fifo_empty_i;
    logic        fifo_rden_o;
    logic [31:0] paddr_o;
    logic [1:0]  psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [31:0] pwdata_o;
    logic [31:0] prdata_i = '0;
    logic        pready_i = 1'b0;
    logic        pslverr_i = 1'b0;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_master_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_trans_i    (wr_trans_i),
        .rd_trans_i    (rd_trans_i),
        .trans_addr_i  (trans_addr_i),
        .burst_len_i   (burst_len_i),
        .read_data_o   (read_data_o),
        .trans_done_o  (trans_done_o),
        .trans_error_o (trans_error_o),
        .fifo_rdata_i  (fifo_rdata_i),
        .fifo_empty_i  (fifo_empty_i),
        .fifo_rden_o   (fifo_rden_o),
        .paddr_o       (paddr_o),
        .psel_o        (psel_o),
        .penable_o     (penable_o),
        .pwrite_o      (pwrite_o),
        .pwdata_o      (pwdata_o),
        .prdata_i      (prdata_i),
        .pready_i      (pready_i),
        .pslverr_i     (pslverr_i),
        .busy_o        (busy_o)
    );

    // Show-ahead write FIFO: the bench pushes, the DUT pops.
    logic [31:0] fifo_mem [0:63];
    int          fifo_wr = 0;
    int          fifo_rd = 0;

    assign fifo_empty_i = (fifo_wr == fifo_rd);
    assign fifo_rdata_i = fifo_mem[fifo_rd[5:0]];

    always @(posedge clk) begin
        if (fifo_rden_o && !fifo_empty_i) fifo_rd <= fifo_rd + 1;
    end

    // APB slave: answers after slv_waits ACCESS cycles and logs each completed transfer.
    int          slv_waits = 0;
    logic        slv_ready_en = 1'b1;
    int          slv_err_xfer = -1;
    logic [31:0] slv_rdata = '0;
    int          acc_cnt = 0;
    int          xfer_cnt = 0;
    logic [31:0] xfer_addr  [0:63];
    logic [31:0] xfer_wdata [0:63];
    logic        xfer_write [0:63];
    logic [1:0]  xfer_sel   [0:63];

    always @(negedge clk) begin
        if (psel_o != 2'b00 && penable_o) begin
            if (slv_ready_en && acc_cnt >= slv_waits) begin
                pready_i  = 1'b1;
                pslverr_i = (xfer_cnt == slv_err_xfer);
                prdata_i  = slv_rdata + 32'(xfer_cnt);
                xfer_addr[xfer_cnt[5:0]]  = paddr_o;
                xfer_wdata[xfer_cnt[5:0]] = pwdata_o;
                xfer_write[xfer_cnt[5:0]] = pwrite_o;
                xfer_sel[xfer_cnt[5:0]]   = psel_o;
                xfer_cnt = xfer_cnt + 1;
            end else begin
                pready_i  = 1'b0;
                pslverr_i = 1'b0;
            end
            acc_cnt = acc_cnt + 1;
        end else begin
            acc_cnt   = 0;
            pready_i  = 1'b0;
            pslverr_i = 1'b0;
        end
    end

    int          done_cnt = 0;
    int          rden_cnt = 0;
    int          psel_cnt = 0;
    int          pen_cnt = 0;
    logic [31:0] done_data [0:63];
    logic        done_err  [0:63];

    always @(negedge clk) begin
        if (trans_done_o) begin
            done_data[done_cnt[5:0]] = read_data_o;
            done_err[done_cnt[5:0]]  = trans_error_o;
            done_cnt = done_cnt + 1;
        end
        if (fifo_rden_o) rden_cnt = rden_cnt + 1;
        if (psel_o != 2'b00) psel_cnt = psel_cnt + 1;
        if (penable_o) pen_cnt = pen_cnt + 1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt >= target && !busy_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic push(input logic [31:0] value);
        fifo_mem[fifo_wr[5:0]] = value;
        fifo_wr = fifo_wr + 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        checks++;
        if ({busy_o, psel_o, penable_o, pwrite_o, trans_done_o, trans_error_o, fifo_rden_o} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000000",
                     {busy_o, psel_o, penable_o, pwrite_o, trans_done_o, trans_error_o, fifo_rden_o});
        end
        checks++;
        if ({paddr_o, pwdata_o, read_data_o} !== 96'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h %h %h expected 0", paddr_o, pwdata_o, read_data_o);
        end
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_single_read();
        int d0 = done_cnt;
        int x0 = xfer_cnt;
        int ps0 = psel_cnt;
        int pe0 = pen_cnt;
        bit ok;
        slv_waits    = 0;
        slv_rdata    = 32'hDEAD_BEEF - 32'(x0);
        trans_addr_i = 32'h0001_F010;
        burst_len_i  = 4'd0;
        rd_trans_i   = 1'b1;
        step(1);
        rd_trans_i = 1'b0;
        wait_done(d0 + 1, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL single_read_done: got no completion expected done"); end
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("[TB] FAIL single_read_strobes: got %0d expected 1", done_cnt - d0); end
        checks++;
        if (done_data[d0[5:0]] !== 32'hDEAD_BEEF || done_err[d0[5:0]] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_read_data: got %h err %b expected deadbeef err 0", done_data[d0[5:0]], done_err[d0[5:0]]);
        end
        checks++;
        if (psel_cnt - ps0 != 2 || pen_cnt - pe0 != 1) begin
            errors++;
            $display("[TB] FAIL single_read_timing: got psel %0d penable %0d expected 2 1", psel_cnt - ps0, pen_cnt - pe0);
        end
        checks++;
        if (xfer_sel[x0[5:0]] !== 2'b01 || xfer_addr[x0[5:0]] !== 32'h0001_F010 || xfer_write[x0[5:0]] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_read_apb: got sel %b addr %h wr %b expected 01 0001f010 0",
                     xfer_sel[x0[5:0]], xfer_addr[x0[5:0]], xfer_write[x0[5:0]]);
        end
    endtask

    task automatic test_write_burst();
        int d0 = done_cnt;
        int x0 = xfer_cnt;
        int r0 = rden_cnt;
        bit ok;
        for (int i = 0; i < 4; i++) push(32'h0000_00A0 + 32'(i));
        slv_waits    = 1;
        trans_addr_i = 32'h0002_F000;
        burst_len_i  = 4'd3;
        wr_trans_i   = 1'b1;
        step(1);
        wr_trans_i = 1'b0;
        wait_done(d0 + 1, 60, ok);
        checks++;
        if (!ok || done_cnt - d0 != 1 || done_err[d0[5:0]] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_burst_done: got ok %0d strobes %0d err %b expected 1 1 0", ok, done_cnt - d0, done_err[d0[5:0]]);
        end
        checks++;
        if (rden_cnt - r0 != 4 || xfer_cnt - x0 != 4) begin
            errors++;
            $display("[TB] FAIL write_burst_counts: got pops %0d xfers %0d expected 4 4", rden_cnt - r0, xfer_cnt - x0);
        end
        for (int i = 0; i < 4; i++) begin
            int k = x0 + i;
            checks++;
            if (xfer_addr[k[5:0]] !== 32'h0002_F000 + 32'(4 * i) || xfer_wdata[k[5:0]] !== 32'h0000_00A0 + 32'(i)
                || xfer_write[k[5:0]] !== 1'b1 || xfer_sel[k[5:0]] !== 2'b10) begin
                errors++;
                $display("[TB] FAIL write_burst_beat%0d: got addr %h data %h wr %b sel %b expected %h %h 1 10", i,
                         xfer_addr[k[5:0]], xfer_wdata[k[5:0]], xfer_write[k[5:0]], xfer_sel[k[5:0]],
                         32'h0002_F000 + 32'(4 * i), 32'h0000_00A0 + 32'(i));
            end
        end
    endtask

    task automatic test_page_wrap();
        int d0 = done_cnt;
        int x0 = xfer_cnt;
        bit ok;
        slv_waits    = 0;
        slv_rdata    = 32'h1234_0000 - 32'(x0);
        trans_addr_i = 32'h0001_FFFC;
        burst_len_i  = 4'd1;
        rd_trans_i   = 1'b1;
        step(1);
        rd_trans_i = 1'b0;
        wait_done(d0 + 2, 30, ok);
        checks++;
        if (!ok || done_cnt - d0 != 2) begin errors++; $display("[TB] FAIL wrap_strobes: got %0d expected 2", done_cnt - d0); end
        checks++;
        if (xfer_addr[x0[5:0]] !== 32'h0001_FFFC || xfer_addr[6'(x0 + 1)] !== 32'h0001_F000) begin
            errors++;
            $display("[TB] FAIL wrap_addr: got %h %h expected 0001fffc 0001f000", xfer_addr[x0[5:0]], xfer_addr[6'(x0 + 1)]);
        end
        checks++;
        if (done_data[d0[5:0]] !== 32'h1234_0000 || done_data[6'(d0 + 1)] !== 32'h1234_0001) begin
            errors++;
            $display("[TB] FAIL wrap_data: got %h %h expected 12340000 12340001", done_data[d0[5:0]], done_data[6'(d0 + 1)]);
        end
    endtask

    task automatic test_decode_miss();
        int d0 = done_cnt;
        int x0 = xfer_cnt;
        int ps0 = psel_cnt;
        bit ok;
        trans_addr_i = 32'h0003_0000;
        burst_len_i  = 4'd0;
        rd_trans_i   = 1'b1;
        step(1);
        rd_trans_i = 1'b0;
        wait_done(d0 + 1, 20, ok);
        checks++;
        if (psel_cnt - ps0 != 0 || xfer_cnt - x0 != 0) begin
            errors++;
            $display("[TB] FAIL miss_psel: got psel cycles %0d xfers %0d expected 0 0", psel_cnt - ps0, xfer_cnt - x0);
        end
        checks++;
        if (!ok || done_cnt - d0 != 1 || done_err[d0[5:0]] !== 1'b1 || done_data[d0[5:0]] !== 32'h0) begin
            errors++;
            $display("[TB] FAIL miss_done: got strobes %0d err %b data %h expected 1 1 0", done_cnt - d0, done_err[d0[5:0]], done_data[d0[5:0]]);
        end
    endtask

    task automatic test_timeout();
        int d0 = done_cnt;
        int x0 = xfer_cnt;
        int pe0 = pen_cnt;
        int r0 = rden_cnt;
        bit ok;
        push(32'h5555_5555);
        slv_ready_en = 1'b0;
        trans_addr_i = 32'h0001_F008;
        burst_len_i  = 4'd0;
        wr_trans_i   = 1'b1;
        step(1);
        wr_trans_i = 1'b0;
        wait_done(d0 + 1, 60, ok);
        slv_ready_en = 1'b1;
        checks++;
        if (!ok || done_cnt - d0 != 1 || done_err[d0[5:0]] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_done: got ok %0d strobes %0d err %b expected 1 1 1", ok, done_cnt - d0, done_err[d0[5:0]]);
        end
        checks++;
        if (pen_cnt - pe0 != 16 || xfer_cnt - x0 != 0 || rden_cnt - r0 != 1) begin
            errors++;
            $display("[TB] FAIL timeout_access: got penable %0d xfers %0d pops %0d expected 16 0 1",
                     pen_cnt - pe0, xfer_cnt - x0, rden_cnt - r0);
        end
    endtask

    task automatic test_slverr_burst();
        int d0 = done_cnt;
        int x0 = xfer_cnt;
        bit ok;
        for (int i = 0; i < 4; i++) push(32'h0000_00B0 + 32'(i));
        slv_waits    = 0;
        slv_err_xfer = x0 + 1;
        trans_addr_i = 32'h0002_F010;
        burst_len_i  = 4'd3;
        wr_trans_i   = 1'b1;
        step(1);
        wr_trans_i = 1'b0;
        wait_done(d0 + 1, 60, ok);
        slv_err_xfer = -1;
        checks++;
        if (xfer_cnt - x0 != 4 || xfer_addr[6'(x0 + 3)] !== 32'h0002_F01C) begin
            errors++;
            $display("[TB] FAIL slverr_beats: got xfers %0d last addr %h expected 4 0002f01c", xfer_cnt - x0, xfer_addr[6'(x0 + 3)]);
        end
        checks++;
        if (!ok || done_cnt - d0 != 1 || done_err[d0[5:0]] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL slverr_done: got strobes %0d err %b expected 1 1", done_cnt - d0, done_err[d0[5:0]]);
        end
    endtask

    task automatic test_simultaneous();
        int d0 = done_cnt;
        int x0 = xfer_cnt;
        int r0 = rden_cnt;
        bit ok;
        slv_rdata    = 32'hCAFE_0000 - 32'(x0);
        trans_addr_i = 32'h0002_F020;
        burst_len_i  = 4'd0;
        rd_trans_i   = 1'b1;
        wr_trans_i   = 1'b1;
        step(1);
        rd_trans_i = 1'b0;
        wr_trans_i = 1'b0;
        wait_done(d0 + 1, 20, ok);
        step(5);
        checks++;
        if (!ok || done_cnt - d0 != 1 || busy_o !== 1'b0 || rden_cnt - r0 != 0) begin
            errors++;
            $display("[TB] FAIL simul_only_read: got strobes %0d busy %b pops %0d expected 1 0 0", done_cnt - d0, busy_o, rden_cnt - r0);
        end
        checks++;
        if (xfer_cnt - x0 != 1 || xfer_write[x0[5:0]] !== 1'b0 || done_data[d0[5:0]] !== 32'hCAFE_0000) begin
            errors++;
            $display("[TB] FAIL simul_read_data: got xfers %0d wr %b data %h expected 1 0 cafe0000",
                     xfer_cnt - x0, xfer_write[x0[5:0]], done_data[d0[5:0]]);
        end
    endtask

    task automatic test_reset_mid_access();
        int d0 = done_cnt;
        bit seen = 1'b0;
        slv_ready_en = 1'b0;
        trans_addr_i = 32'h0001_F000;
        burst_len_i  = 4'd0;
        rd_trans_i   = 1'b1;
        step(1);
        rd_trans_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (penable_o) begin
                seen = 1'b1;
                break;
            end
            step(1);
        end
        checks++;
        if (!seen) begin errors++; $display("[TB] FAIL midreset_access: got no ACCESS expected penable"); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_o, psel_o, penable_o, pwrite_o, trans_done_o, trans_error_o, fifo_rden_o} !== 8'h00
            || {paddr_o, pwdata_o, read_data_o} !== 96'h0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got ctrl %b addr %h expected 0 0",
                     {busy_o, psel_o, penable_o, pwrite_o, trans_done_o, trans_error_o, fifo_rden_o}, paddr_o);
        end
        step(2);
        rst_n = 1'b1;
        slv_ready_en = 1'b1;
        step(20);
        checks++;
        if (done_cnt - d0 != 0 || busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_no_done: got strobes %0d busy %b expected 0 0", done_cnt - d0, busy_o);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single_read();
        test_write_burst();
        test_page_wrap();
        test_decode_miss();
        test_timeout();
        test_slverr_burst();
        test_simultaneous();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
- APB-side engine of the AXI-to-APB bridge; the other end of the bridge's internal transaction interface.
- Accepts read/write burst requests (address, burst length, write data from the write FIFO) and executes each beat as an APB3 SETUP/ACCESS transfer to one of two 4 KB slave windows.
- Returns per-beat read data, completion strobes and error status to the AXI-side handler.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- TIMEOUT_CYCLES, 16, max ACCESS cycles waiting for pready_i before forced error; 0 disables the timeout.
- SLV0_BASE, 32'h0001_F000, 4 KB window decoded to psel_o[0].
- SLV1_BASE, 32'h0002_F000, 4 KB window decoded to psel_o[1].

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wr_trans_i  in  1  write request level; start on rising edge
- rd_trans_i  in  1  read request level; start on rising edge
- trans_addr_i  in  ADDR_WIDTH  burst start address, sampled at start
- burst_len_i  in  4  beats minus 1, sampled at start
- read_data_o  out  DATA_WIDTH  read beat data
- trans_done_o  out  1  one-cycle completion strobe
- trans_error_o  out  1  error qualifier, valid with trans_done_o
- fifo_rdata_i  in  DATA_WIDTH  write FIFO head (show-ahead)
- fifo_empty_i  in  1  write FIFO empty
- fifo_rden_o  out  1  write FIFO pop
- paddr_o  out  ADDR_WIDTH  APB address
- psel_o  out  2  one-hot slave select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB direction
- pwdata_o  out  DATA_WIDTH  APB write data
- prdata_i  in  DATA_WIDTH  muxed slave read data
- pready_i  in  1  muxed slave ready
- pslverr_i  in  1  muxed slave error
- busy_o  out  1  burst in progress (state != IDLE)

Behaviour:
- Reset: all outputs 0, FSM in IDLE, edge detectors cleared.
- Reset mid-burst: the burst is abandoned; no trans_done_o is issued.
- FSM states: IDLE, WAIT_DATA, SETUP, ACCESS.
- Start: in IDLE, a rising edge of rd_trans_i or wr_trans_i latches the address, burst_len_i and direction.
  - Read → SETUP; write → WAIT_DATA.
  - Simultaneous edges: read wins; the write edge is dropped.
  - Edges while busy are ignored.
- WAIT_DATA: when !fifo_empty_i, pulse fifo_rden_o for 1 cycle, register pwdata_o <= fifo_rdata_i, go to SETUP. Wait indefinitely while empty.
- Decode: slave 0 when addr[ADDR_WIDTH-1:12] == SLV0_BASE[ADDR_WIDTH-1:12]; slave 1 likewise for SLV1_BASE.
  - Undecoded beat: no psel, no APB cycle; the beat completes with error one cycle after SETUP entry.
- SETUP (1 cycle): psel_o one-hot, penable_o 0, paddr_o and pwrite_o driven → ACCESS.
- ACCESS: psel_o held, penable_o 1. All APB outputs stay stable until the beat ends.
  - Beat ends when pready_i = 1, or when the wait counter reaches TIMEOUT_CYCLES (error, read data 0).
  - Beat error = pslverr_i OR timeout OR decode miss.
  - On beat end, psel_o and penable_o drop the next cycle unless the next beat's SETUP follows immediately.
- Read completion:
  - Each beat: read_data_o <= prdata_i and trans_done_o pulses the cycle after the beat ends.
  - trans_error_o reflects that beat's error.
  - read_data_o holds until the next beat.
- Write completion:
  - No per-beat strobe; the error is OR-accumulated across beats.
  - A single trans_done_o pulse, with the accumulated error, follows the final beat.
- Beat count: burst_len_i + 1 beats (1..16).
  - After a non-final beat: addr[11:2] += 1, wrapping within the 4 KB page (upper bits unchanged); read → SETUP, write → WAIT_DATA.
  - After the final beat → IDLE.
- Wait counter: cleared on ACCESS entry; saturating; must not fire when TIMEOUT_CYCLES = 0.
- Minimum beat time: read 2 cycles with zero-wait slave; write 3 cycles (includes FIFO fetch).

Decomposition:
- Package apb_bridge_pkg holds:
  - FSM enum apb_state_t.
  - Slave base constants and the 4 KB window mask.
  - Response constants shared with the AXI side: OKAY = 2'b00, SLVERR = 2'b10.
- One natural sub-module: apb_addr_decode. Combinational; address in, one-hot select plus hit out.

Test Plan:
- Single read at 0x0001_F010, pready high in ACCESS, prdata 0xDEADBEEF → psel_o = 01 for 2 cycles, penable_o on the 2nd; trans_done_o = 1 with read_data_o = 0xDEADBEEF, error 0.
- Write burst len 3 at 0x0002_F000, FIFO holds A0..A3, 1 wait state per beat → 4 APB writes to F000/F004/F008/F00C with psel_o = 10; 4 fifo_rden_o pulses; one trans_done_o, error 0.
- Read burst len 1 at 0x0001_FFFC → second beat paddr_o = 0x0001_F000 (page wrap); 2 done strobes.
- Read at 0x0003_0000 → no psel_o assertion; trans_done_o with trans_error_o = 1.
- Write with pready low for 16 ACCESS cycles (TIMEOUT_CYCLES = 16) → beat aborted, done with error 1. Separately, pslverr_i on beat 2 of 4 → all 4 beats run, final done error 1.
- rd_trans_i and wr_trans_i rise together → read executes, write ignored. Separately, rst_n low during ACCESS → all outputs 0 and no done pulse after release.
